// File: rtl/rc5_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : rc5_key_expand
// Purpose  : RC5-16 key schedule. Expands a 128-bit user key into the 34-entry
//            16-bit subkey table S[0..33] consumed by the round engine.
//            Iterative: magic-constant fill on the accept edge, then one
//            mixing step per clock for 3*max(T,C) = 102 steps.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous reset, active low
//            start    - request expansion (sampled only while idle)
//            key      - user key, L[j] = key[16j+15:16j]
//            subkeys  - S[i] at [16i+15:16i], driven straight from the table
//            busy     - expansion in progress
//            valid    - subkeys holds the complete table for the last key
//            done     - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module rc5_key_expand #(
    parameter int          W       = 16,
    parameter int          T       = 34,
    parameter int          C       = 8,
    parameter logic [15:0] P_CONST = 16'hB7E1,
    parameter logic [15:0] Q_CONST = 16'h9E37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [C*W-1:0]   key,
    output logic [T*W-1:0]   subkeys,
    output logic             busy,
    output logic             valid,
    output logic             done
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MIX  = 1'b1;

    localparam logic [5:0] c_last_i   = 6'(T - 1);
    // T > C, so the mixing pass count is 3*T.
    localparam logic [6:0] c_last_cnt = 7'(3 * T - 1);

    logic [0:0]   r_state;
    logic [W-1:0] r_s [0:T-1];
    logic [W-1:0] r_l [0:C-1];
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [5:0]   r_i;
    logic [2:0]   r_j;
    logic [6:0]   r_cnt;
    logic         r_valid;
    logic         r_done;

    // One mixing step: two 3-input adds and a variable rotate in series.
    logic [W-1:0]   w_s_sum;
    logic [W-1:0]   w_s_new;
    logic [W-1:0]   w_sb;
    logic [W-1:0]   w_l_sum;
    logic [2*W-1:0] w_l_dbl;
    logic [W-1:0]   w_l_new;

    always_comb begin
        w_s_sum = r_s[r_i] + r_a + r_b;
        w_s_new = {w_s_sum[W-4:0], w_s_sum[W-1:W-3]};
        w_sb    = w_s_new + r_b;
        w_l_sum = r_l[r_j] + w_sb;
        // Rotate-left by shifting a doubled copy; the upper half holds the result.
        w_l_dbl = {w_l_sum, w_l_sum} << w_sb[3:0];
        w_l_new = w_l_dbl[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            for (int k = 0; k < T; k++) r_s[k] <= '0;
            for (int k = 0; k < C; k++) r_l[k] <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < C; k++) r_l[k] <= key[k*W +: W];
                        for (int k = 0; k < T; k++) r_s[k] <= P_CONST + W'(k) * Q_CONST;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_state <= MIX;
                    end
                end
                MIX: begin
                    r_s[r_i] <= w_s_new;
                    r_a      <= w_s_new;
                    r_l[r_j] <= w_l_new;
                    r_b      <= w_l_new;
                    r_i      <= (r_i == c_last_i) ? 6'd0 : r_i + 6'd1;
                    r_j      <= r_j + 3'd1;
                    r_cnt    <= r_cnt + 7'd1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= IDLE;
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < T; g++) begin : g_pack
            assign subkeys[g*W +: W] = r_s[g];
        end
    endgenerate

    assign busy  = (r_state == MIX);
    assign valid = r_valid;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/rc5_key_expand.md
# rc5_key_expand

RC5-16 key-schedule generator sitting directly upstream of the round engine: expands a 128-bit user key into the 34-entry 16-bit subkey table S[0..33] that the encrypt/decrypt datapath consumes. Implements the standard RC5 expansion (magic-constant fill, then 3·max(t,c) mixing passes) as a multi-cycle iterative FSM, one mixing step per clock. Presents the table as a flat bus plus a `valid` level and a one-cycle `done` pulse.

## Interface
- `W`, 16, word width; fixed, other values unsupported.
- `T`, 34, subkey count (2·16 rounds + 2); the round engine indexes S[0..T-1].
- `C`, 8, key words (128-bit key / W).
- `P_CONST`, 16'hB7E1, RC5 magic P16.
- `Q_CONST`, 16'h9E37, RC5 magic Q16.

- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset rst, synchronous, active-low; clock clk.
- `start` in 1: request expansion; sampled only in IDLE.
- `key` in 128: user key; L[j] = key[16j+15:16j] (byte k = key[8k+7:8k], little-endian words).
- `subkeys` out 544: S[i] at [16i+15:16i]; S[0] feeds pre-whitening of A, S[1] of B.
- `busy` out 1: high while expansion in progress.
- `valid` out 1: level; `subkeys` is a complete table for the last accepted key.
- `done` out 1: one-cycle pulse at completion.

## Operation
- States: IDLE, MIX. Registers: S[0..33], L[0..7], A, B (16b), i (6b, 0..33), j (3b), cnt (7b, 0..101).
- Reset (rst==0 at edge): state=IDLE; S, L, A, B, i, j, cnt = 0; busy=0, valid=0, done=0. Applies mid-MIX; partial work discarded.
- IDLE, start==1 (accept edge): L[j] <= key words; S[k] <= P_CONST + k·Q_CONST mod 2^16 for all k in parallel; A=B=i=j=cnt=0; valid<=0; busy<=1; state<=MIX.
- IDLE, start==0: hold everything; done<=0.
- MIX, one step per edge, using current-cycle register values:
  - s' = rotl(S[i] + A + B, 3); S[i] <= s'; A <= s'.
  - l' = rotl(L[j] + s' + B, (s' + B) mod 16); L[j] <= l'; B <= l'.
  - i <= (i==33) ? 0 : i+1; j <= j+1 (natural wrap at 8); cnt <= cnt+1.
  - When cnt==101 (step 102 performed this edge): state<=IDLE, busy<=0, valid<=1, done<=1.
- All adds mod 2^16; rotl amount is 3 for S, low 4 bits of (s'+B) for L; rotation by 0 is identity.
- `start` during MIX ignored (no queue); `key` changes after accept edge have no effect.
- `valid` stays high until next accepted start or reset. `subkeys` always drives S registers directly; contents are intermediate while busy and must not be consumed while valid==0.

## Timing
- Accept edge E0; MIX steps at edges E1..E102; done=1 and valid=1 in cycle following E102; busy=1 in cycles after E0 through E102 (102 cycles).
- Start-to-done latency: 102 cycles. Back-to-back: start high in the done cycle is accepted (state is IDLE), valid drops next cycle.
- done never asserts on an accept edge; exactly one pulse per accepted start not killed by reset.
- Critical path: two 3-input 16b adds + 16b barrel rotate in series.

## Test plan
- Reset: hold rst=0 2 cycles with start=1 -> busy=0, valid=0, done=0, subkeys=0; no transition.
- Constant fill: key=0, pulse start; cycle after accept -> S[0]=16'hB7E1, S[1]=16'h5618, S[33]=16'h1CF8, busy=1, valid=0.
- First mix step: key=0; one cycle later -> S[0]=16'hBF0D, S[1] still 16'h5618.
- Full expansion: keys 0, all-ones, 128'h0F0E..0100 -> done exactly 102 cycles after accept, one cycle wide; all 34 S[i] match software golden model; valid held until next start.
- Start/key ignored mid-run: pulse start and change key at cycle 50 of MIX -> completion still at cycle 102, table equals first key's golden result; no second done.
- Reset mid-MIX at cycle 60 then restart with key 1 -> no done from aborted run; new done 102 cycles after new accept with key-1 golden table.
